debounce_multi: RTL and testbench

Parametrised multi-channel debouncer for push-buttons and slide switches on the FPGA kit wrapper. Each channel synchronises a raw asynchronous input, applies a counter-based stability filter, and produces a debounced level plus single-cycle press and release ticks. An optional auto-repeat generator emits periodic ticks while a button is held. It sits between the kit pins and the interrupt/peripheral logic that consumes button events.

---
 rtl/debounce_multi.sv | 201 ++++++++++++++++++++
 tb/tb_debounce_multi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel push-button / switch debouncer: synchroniser, counter-qualified FSM, press/release ticks.
// Optional auto-repeat ticks while held are compiled in with `define DEBOUNCE_REPEAT_EN.
module debounce_multi #(
    parameter int CH          = 4,
    parameter int CNT_W       = 20,
    parameter int SYNC_STAGES = 2,
    parameter int REP_DLY_W   = 24,
    parameter int REP_PER_W   = 22
) (
    input  logic          clk_50MHz,
    input  logic          rst_n,
    input  logic [CH-1:0] btn,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] db_rise,
    output logic [CH-1:0] db_fall,
    output logic [CH-1:0] db_repeat
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   s_s;
        state_t                 state_r;
        state_t                 state_s;
        logic [CNT_W-1:0]       cnt_r;
        logic [CNT_W-1:0]       cnt_s;
        logic                   level_s;
        logic                   level_r;
        logic                   rise_r;
        logic                   fall_r;

        assign s_s = sync_r[SYNC_STAGES-1];

        // Synchroniser chain for the raw pin
        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                sync_r <= '0;
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], btn[gi]};
            end
        end

        // FSM state and stability counter registers
        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= ZERO;
                cnt_r   <= '0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
            end
        end

        // Next-state logic: a level qualifies only after the full window without a bounce
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            case (state_r)
                ZERO: begin
                    if (s_s) begin
                        state_s = WAIT1;
                        cnt_s   = '1;
                    end else begin
                        state_s = ZERO;
                    end
                end
                WAIT1: begin
                    if (!s_s) begin
                        state_s = ZERO;
                    end else if (cnt_r != '0) begin
                        cnt_s = cnt_r - CNT_W'(1'b1);
                    end else begin
                        state_s = ONE;
                    end
                end
                ONE: begin
                    if (!s_s) begin
                        state_s = WAIT0;
                        cnt_s   = '1;
                    end else begin
                        state_s = ONE;
                    end
                end
                WAIT0: begin
                    if (s_s) begin
                        state_s = ONE;
                    end else if (cnt_r != '0) begin
                        cnt_s = cnt_r - CNT_W'(1'b1);
                    end else begin
                        state_s = ZERO;
                    end
                end
                default: begin
                    state_s = ZERO;
                    cnt_s   = '0;
                end
            endcase
        end

        // Output decode of the debounced level
        always_comb begin
            case (state_r)
                ONE, WAIT0: level_s = 1'b1;
                default:    level_s = 1'b0;
            endcase
        end

        // Registered level and edge ticks, aligned to the same cycle
        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                level_r <= 1'b0;
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
            end else begin
                level_r <= level_s;
                rise_r  <= level_s & ~level_r;
                fall_r  <= ~level_s & level_r;
            end
        end

        assign db_level[gi] = level_r;
        assign db_rise[gi]  = rise_r;
        assign db_fall[gi]  = fall_r;

`ifdef DEBOUNCE_REPEAT_EN
        logic [REP_DLY_W-1:0] dly_r;
        logic [REP_DLY_W-1:0] dly_s;
        logic [REP_PER_W-1:0] per_r;
        logic [REP_PER_W-1:0] per_s;
        logic                 rep_on_r;
        logic                 rep_on_s;
        logic                 rep_evt_s;
        logic                 rep_evt_r;
        logic                 rep_r;

        // Repeat timing: initial delay once per press, then fixed period until released
        always_comb begin
            dly_s     = dly_r;
            per_s     = per_r;
            rep_on_s  = rep_on_r;
            rep_evt_s = 1'b0;
            if (state_s == ZERO) begin
                dly_s    = '0;
                per_s    = '0;
                rep_on_s = 1'b0;
            end else if ((state_r == WAIT1) && (state_s == ONE)) begin
                dly_s    = '1;
                per_s    = '0;
                rep_on_s = 1'b0;
            end else if (level_s) begin
                if (!rep_on_r) begin
                    if (dly_r != '0) begin
                        dly_s = dly_r - REP_DLY_W'(1'b1);
                    end else begin
                        rep_evt_s = 1'b1;
                        per_s     = '1;
                        rep_on_s  = 1'b1;
                    end
                end else begin
                    if (per_r != '0) begin
                        per_s = per_r - REP_PER_W'(1'b1);
                    end else begin
                        rep_evt_s = 1'b1;
                        per_s     = '1;
                    end
                end
            end else begin
                rep_on_s = rep_on_r;
            end
        end

        // Repeat counters; the event is delayed one stage to line up with the level/tick outputs
        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                dly_r     <= '0;
                per_r     <= '0;
                rep_on_r  <= 1'b0;
                rep_evt_r <= 1'b0;
                rep_r     <= 1'b0;
            end else begin
                dly_r     <= dly_s;
                per_r     <= per_s;
                rep_on_r  <= rep_on_s;
                rep_evt_r <= rep_evt_s;
                rep_r     <= rep_evt_r;
            end
        end

        assign db_repeat[gi] = rep_r;
`else
        assign db_repeat[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with a 16-clock window, 2-flop synchroniser and short repeat timers.
module tb_debounce_multi;

    localparam int CH = 4;

    logic          clk_50MHz = 1'b0;
    logic          rst_n;
    logic [CH-1:0] btn;
    logic [CH-1:0] db_level;
    logic [CH-1:0] db_rise;
    logic [CH-1:0] db_fall;
    logic [CH-1:0] db_repeat;

    int checks = 0;
    int errors = 0;

    debounce_multi #(
        .CH          (CH),
        .CNT_W       (4),
        .SYNC_STAGES (2),
        .REP_DLY_W   (5),
        .REP_PER_W   (3)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .btn       (btn),
        .db_level  (db_level),
        .db_rise   (db_rise),
        .db_fall   (db_fall),
        .db_repeat (db_repeat)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 4'h0;
        repeat (3) @(negedge clk_50MHz);
        checks++;
        if ({db_level, db_rise, db_fall, db_repeat} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state got %h want %h", {db_level, db_rise, db_fall, db_repeat}, 16'h0000);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50MHz);
        checks++;
        if ({db_level, db_rise, db_fall, db_repeat} !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_idle got %h want %h", {db_level, db_rise, db_fall, db_repeat}, 16'h0000);
        end
    endtask

    task automatic test_single_press();
        btn[0] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_50MHz);
            checks++;
            if (db_rise !== ((k == 19) ? 4'b0001 : 4'b0000) ||
                db_level !== ((k >= 19) ? 4'b0001 : 4'b0000) || db_fall !== 4'b0000) begin
                errors++;
                $display("FAIL single_press k=%0d rise=%b level=%b fall=%b want rise=%b level=%b",
                         k, db_rise, db_level, db_fall, (k == 19) ? 4'b0001 : 4'b0000,
                         (k >= 19) ? 4'b0001 : 4'b0000);
            end
        end
        btn[0] = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_50MHz);
            checks++;
            if (db_fall[0] !== (k == 19) || db_level[0] !== (k < 19)) begin
                errors++;
                $display("FAIL single_release k=%0d fall=%b level=%b want fall=%b level=%b",
                         k, db_fall[0], db_level[0], (k == 19), (k < 19));
            end
        end
    endtask

    task automatic test_bounce();
        btn[1] = 1'b1;
        repeat (10) begin
            @(negedge clk_50MHz);
            checks++;
            if (db_rise[1] !== 1'b0 || db_level[1] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_high rise=%b level=%b want 0 0", db_rise[1], db_level[1]);
            end
        end
        btn[1] = 1'b0;
        repeat (3) begin
            @(negedge clk_50MHz);
            checks++;
            if (db_rise[1] !== 1'b0 || db_level[1] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_low rise=%b level=%b want 0 0", db_rise[1], db_level[1]);
            end
        end
        btn[1] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_50MHz);
            checks++;
            if (db_rise[1] !== (k == 19) || db_level[1] !== (k >= 19)) begin
                errors++;
                $display("FAIL bounce_settle k=%0d rise=%b level=%b want rise=%b level=%b",
                         k, db_rise[1], db_level[1], (k == 19), (k >= 19));
            end
        end
        btn[1] = 1'b0;
        repeat (25) @(negedge clk_50MHz);
        checks++;
        if (db_level !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_cleanup level=%b want %b", db_level, 4'b0000);
        end
    endtask

    task automatic test_release();
        btn[2] = 1'b1;
        repeat (25) @(negedge clk_50MHz);
        checks++;
        if (db_level !== 4'b0100) begin
            errors++;
            $display("FAIL release_setup level=%b want %b", db_level, 4'b0100);
        end
        btn[2] = 1'b0;
        for (int k = 0; k < 35; k++) begin
            if (k == 10) btn[2] = 1'b1;
            @(negedge clk_50MHz);
            checks++;
            if (db_fall[2] !== 1'b0 || db_level[2] !== 1'b1) begin
                errors++;
                $display("FAIL release_glitch k=%0d fall=%b level=%b want 0 1", k, db_fall[2], db_level[2]);
            end
        end
        btn[2] = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_50MHz);
            checks++;
            if (db_fall[2] !== (k == 19) || db_level[2] !== (k < 19) || db_rise !== 4'b0000) begin
                errors++;
                $display("FAIL release_fall k=%0d fall=%b level=%b rise=%b want fall=%b level=%b",
                         k, db_fall[2], db_level[2], db_rise, (k == 19), (k < 19));
            end
        end
    endtask

    task automatic test_simultaneous();
        btn = 4'hF;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_50MHz);
            checks++;
            if (db_rise !== ((k == 19) ? 4'hF : 4'h0) || db_level !== ((k >= 19) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL simul_rise k=%0d rise=%h level=%h want rise=%h level=%h",
                         k, db_rise, db_level, (k == 19) ? 4'hF : 4'h0, (k >= 19) ? 4'hF : 4'h0);
            end
        end
        btn = 4'h0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_50MHz);
            checks++;
            if (db_fall !== ((k == 19) ? 4'hF : 4'h0) || db_level !== ((k < 19) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL simul_fall k=%0d fall=%h level=%h want fall=%h level=%h",
                         k, db_fall, db_level, (k == 19) ? 4'hF : 4'h0, (k < 19) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_reset_midwindow();
        btn[3] = 1'b1;
        repeat (25) @(negedge clk_50MHz);
        checks++;
        if (db_level !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_setup level=%b want %b", db_level, 4'b1000);
        end
        btn[0] = 1'b1;
        repeat (5) @(negedge clk_50MHz);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({db_level, db_rise, db_fall, db_repeat} !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_immediate got %h want %h", {db_level, db_rise, db_fall, db_repeat}, 16'h0000);
        end
        repeat (3) @(negedge clk_50MHz);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_50MHz);
            checks++;
            if (db_rise !== ((k == 19) ? 4'b1001 : 4'b0000) || db_level !== ((k >= 19) ? 4'b1001 : 4'b0000)) begin
                errors++;
                $display("FAIL midrst_requalify k=%0d rise=%b level=%b want rise=%b level=%b",
                         k, db_rise, db_level, (k == 19) ? 4'b1001 : 4'b0000, (k >= 19) ? 4'b1001 : 4'b0000);
            end
        end
        btn = 4'h0;
        repeat (25) @(negedge clk_50MHz);
    endtask

    task automatic test_repeat();
        logic exp_rep;
        btn[0] = 1'b1;
        for (int k = 0; k < 131; k++) begin
            @(negedge clk_50MHz);
`ifdef DEBOUNCE_REPEAT_EN
            exp_rep = (k >= 51) && (k <= 91) && (((k - 51) % 8) == 0);
`else
            exp_rep = 1'b0;
`endif
            checks++;
            if (db_repeat[0] !== exp_rep || db_rise[0] !== (k == 19) || db_fall[0] !== (k == 99) ||
                db_repeat[3:1] !== 3'b000) begin
                errors++;
                $display("FAIL repeat k=%0d rep=%b rise=%b fall=%b want rep=%b rise=%b fall=%b",
                         k, db_repeat, db_rise[0], db_fall[0], exp_rep, (k == 19), (k == 99));
            end
            if (k == 79) btn[0] = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 4'h0;
        test_reset();
        test_single_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_midwindow();
        test_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
